linkspeed_rx: RTL and testbench



---
 rtl/ltsm_sb_pkg.sv | 28 ++
 rtl/linkspeed_rx_req_buf.sv | 38 +++
 rtl/linkspeed_rx.sv | 170 +++++++++++++++++
 tb/tb_linkspeed_rx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltsm_sb_pkg.sv
// Sideband message codes and state type for the MBTRAIN.LINKSPEED handshake.
// Shared by the LINKSPEED initiator and responder FSMs.
package ltsm_sb_pkg;

  localparam int unsigned MSG_W = 4;

  localparam logic [MSG_W-1:0] START_REQ                  = MSG_W'(1);
  localparam logic [MSG_W-1:0] START_RESP                 = MSG_W'(2);
  localparam logic [MSG_W-1:0] ERROR_REQ                  = MSG_W'(3);
  localparam logic [MSG_W-1:0] ERROR_RESP                 = MSG_W'(4);
  localparam logic [MSG_W-1:0] EXIT_TO_REPAIR_REQ         = MSG_W'(5);
  localparam logic [MSG_W-1:0] EXIT_TO_REPAIR_RESP        = MSG_W'(6);
  localparam logic [MSG_W-1:0] EXIT_TO_SPEED_DEGRADE_REQ  = MSG_W'(7);
  localparam logic [MSG_W-1:0] EXIT_TO_SPEED_DEGRADE_RESP = MSG_W'(8);
  localparam logic [MSG_W-1:0] DONE_REQ                   = MSG_W'(9);
  localparam logic [MSG_W-1:0] DONE_RESP                  = MSG_W'(10);
  localparam logic [MSG_W-1:0] EXIT_TO_PHYRETRAIN_REQ     = MSG_W'(11);
  localparam logic [MSG_W-1:0] EXIT_TO_PHYRETRAIN_RESP    = MSG_W'(12);

  typedef enum logic [2:0] {
    LS_IDLE           = 3'd0,
    LS_WAIT_START_REQ = 3'd1,
    LS_POINT_TEST     = 3'd2,
    LS_WAIT_REQ       = 3'd3,
    LS_TEST_FINISHED  = 3'd4
  } linkspeed_state_e;

endpackage

// File: rtl/linkspeed_rx_req_buf.sv
// One-entry buffer holding the latest partner request seen while the point test runs.
// Clear has priority over load; load has priority over consume.
module linkspeed_rx_req_buf #(
  parameter int unsigned MSG_W = ltsm_sb_pkg::MSG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [MSG_W-1:0] i_msg,
  input  logic             i_consume,
  output logic             o_valid,
  output logic [MSG_W-1:0] o_msg
);
  import ltsm_sb_pkg::*;

  logic             r_valid;
  logic [MSG_W-1:0] r_msg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_msg   <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_msg   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_msg   <= i_msg;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_msg   = r_msg;

endmodule

// File: rtl/linkspeed_rx.sv
// MBTRAIN.LINKSPEED responder: answers partner sideband requests, runs the Rx
// point test and records the partner's requested exit path as sticky flags.
module linkspeed_rx #(
  parameter int unsigned NUM_LANES = 16,
  parameter int unsigned MSG_W     = ltsm_sb_pkg::MSG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [MSG_W-1:0]     i_sideband_message,
  input  logic                 i_sideband_valid,
  input  logic                 i_busy_negedge_detected,
  input  logic                 i_point_test_ack,
  input  logic [NUM_LANES-1:0] i_lanes_result,
  output logic [MSG_W-1:0]     o_sideband_message,
  output logic                 o_valid_tx,
  output logic                 o_point_test_en,
  output logic                 o_test_ack,
  output logic [NUM_LANES-1:0] o_lanes_result,
  output logic                 o_error_req_received,
  output logic                 o_repair_req_received,
  output logic                 o_speed_degrade_req_received,
  output logic                 o_phy_retrain_req_received
);
  import ltsm_sb_pkg::*;

  linkspeed_state_e     r_state;
  logic [MSG_W-1:0]     r_msg;
  logic                 r_valid_tx;
  logic                 r_point_test_en;
  logic                 r_test_ack;
  logic [NUM_LANES-1:0] r_lanes_result;
  logic                 r_err_flag;
  logic                 r_repair_flag;
  logic                 r_sd_flag;
  logic                 r_retrain_flag;

  logic                 w_buf_clr;
  logic                 w_buf_load;
  logic                 w_buf_consume;
  logic                 w_buf_valid;
  logic [MSG_W-1:0]     w_buf_msg;
  logic                 w_req_valid;
  logic [MSG_W-1:0]     w_req_msg;

  // Early requests are parked until WAIT_REQ; START_REQ is never parked.
  assign w_buf_clr     = (r_state == LS_IDLE);
  assign w_buf_load    = i_en && (r_state == LS_POINT_TEST) && i_sideband_valid &&
                         (i_sideband_message != MSG_W'(START_REQ));
  assign w_buf_consume = i_en && (r_state == LS_WAIT_REQ) && w_buf_valid;

  assign w_req_valid = w_buf_valid || i_sideband_valid;
  assign w_req_msg   = w_buf_valid ? w_buf_msg : i_sideband_message;

  linkspeed_rx_req_buf #(
    .MSG_W(MSG_W)
  ) u_req_buf (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_buf_clr),
    .i_load   (w_buf_load),
    .i_msg    (i_sideband_message),
    .i_consume(w_buf_consume),
    .o_valid  (w_buf_valid),
    .o_msg    (w_buf_msg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= LS_IDLE;
      r_msg           <= '0;
      r_valid_tx      <= 1'b0;
      r_point_test_en <= 1'b0;
      r_test_ack      <= 1'b0;
      r_lanes_result  <= '0;
      r_err_flag      <= 1'b0;
      r_repair_flag   <= 1'b0;
      r_sd_flag       <= 1'b0;
      r_retrain_flag  <= 1'b0;
    end else begin
      // A response loaded below overrides this clear.
      if (i_busy_negedge_detected) r_valid_tx <= 1'b0;

      if (r_state == LS_IDLE) begin
        r_msg           <= '0;
        r_valid_tx      <= 1'b0;
        r_point_test_en <= 1'b0;
        r_test_ack      <= 1'b0;
        r_lanes_result  <= '0;
        r_err_flag      <= 1'b0;
        r_repair_flag   <= 1'b0;
        r_sd_flag       <= 1'b0;
        r_retrain_flag  <= 1'b0;
        if (i_en) r_state <= LS_WAIT_START_REQ;
      end else if (!i_en) begin
        r_state <= LS_IDLE;
      end else begin
        case (r_state)
          LS_WAIT_START_REQ: begin
            if (i_sideband_valid && (i_sideband_message == MSG_W'(START_REQ))) begin
              r_msg           <= MSG_W'(START_RESP);
              r_valid_tx      <= 1'b1;
              r_point_test_en <= 1'b1;
              r_state         <= LS_POINT_TEST;
            end
          end
          LS_POINT_TEST: begin
            if (i_point_test_ack) begin
              r_lanes_result  <= i_lanes_result;
              r_point_test_en <= 1'b0;
              r_state         <= LS_WAIT_REQ;
            end
          end
          LS_WAIT_REQ: begin
            if (w_req_valid) begin
              case (w_req_msg)
                MSG_W'(DONE_REQ): begin
                  r_msg      <= MSG_W'(DONE_RESP);
                  r_valid_tx <= 1'b1;
                  r_test_ack <= 1'b1;
                  r_state    <= LS_TEST_FINISHED;
                end
                MSG_W'(ERROR_REQ): begin
                  r_msg      <= MSG_W'(ERROR_RESP);
                  r_valid_tx <= 1'b1;
                  r_err_flag <= 1'b1;
                end
                MSG_W'(EXIT_TO_REPAIR_REQ): begin
                  r_msg         <= MSG_W'(EXIT_TO_REPAIR_RESP);
                  r_valid_tx    <= 1'b1;
                  r_repair_flag <= 1'b1;
                  r_test_ack    <= 1'b1;
                  r_state       <= LS_TEST_FINISHED;
                end
                MSG_W'(EXIT_TO_SPEED_DEGRADE_REQ): begin
                  r_msg      <= MSG_W'(EXIT_TO_SPEED_DEGRADE_RESP);
                  r_valid_tx <= 1'b1;
                  r_sd_flag  <= 1'b1;
                  r_test_ack <= 1'b1;
                  r_state    <= LS_TEST_FINISHED;
                end
                MSG_W'(EXIT_TO_PHYRETRAIN_REQ): begin
                  r_msg          <= MSG_W'(EXIT_TO_PHYRETRAIN_RESP);
                  r_valid_tx     <= 1'b1;
                  r_retrain_flag <= 1'b1;
                  r_test_ack     <= 1'b1;
                  r_state        <= LS_TEST_FINISHED;
                end
                default: ;
              endcase
            end
          end
          LS_TEST_FINISHED: r_test_ack <= 1'b1;
          default:          r_state    <= LS_IDLE;
        endcase
      end
    end
  end

  assign o_sideband_message           = r_msg;
  assign o_valid_tx                   = r_valid_tx;
  assign o_point_test_en              = r_point_test_en;
  assign o_test_ack                   = r_test_ack;
  assign o_lanes_result               = r_lanes_result;
  assign o_error_req_received         = r_err_flag;
  assign o_repair_req_received        = r_repair_flag;
  assign o_speed_degrade_req_received = r_sd_flag;
  assign o_phy_retrain_req_received   = r_retrain_flag;

endmodule

// File: tb/tb_linkspeed_rx.sv
// Self-checking bench for linkspeed_rx: directed vector table, async-reset sequence,
// and randomized traffic compared against a request/response reference model.
module tb_linkspeed_rx;

  localparam int unsigned NL = 16;
  localparam int unsigned MW = 4;

  logic          clk;
  logic          rst;
  logic          i_en;
  logic [MW-1:0] i_sideband_message;
  logic          i_sideband_valid;
  logic          i_busy_negedge_detected;
  logic          i_point_test_ack;
  logic [NL-1:0] i_lanes_result;
  logic [MW-1:0] o_sideband_message;
  logic          o_valid_tx;
  logic          o_point_test_en;
  logic          o_test_ack;
  logic [NL-1:0] o_lanes_result;
  logic          o_error_req_received;
  logic          o_repair_req_received;
  logic          o_speed_degrade_req_received;
  logic          o_phy_retrain_req_received;

  linkspeed_rx #(.NUM_LANES(NL), .MSG_W(MW)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .i_en                        (i_en),
    .i_sideband_message          (i_sideband_message),
    .i_sideband_valid            (i_sideband_valid),
    .i_busy_negedge_detected     (i_busy_negedge_detected),
    .i_point_test_ack            (i_point_test_ack),
    .i_lanes_result              (i_lanes_result),
    .o_sideband_message          (o_sideband_message),
    .o_valid_tx                  (o_valid_tx),
    .o_point_test_en             (o_point_test_en),
    .o_test_ack                  (o_test_ack),
    .o_lanes_result              (o_lanes_result),
    .o_error_req_received        (o_error_req_received),
    .o_repair_req_received       (o_repair_req_received),
    .o_speed_degrade_req_received(o_speed_degrade_req_received),
    .o_phy_retrain_req_received  (o_phy_retrain_req_received)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {phy_retrain, speed_degrade, repair, error}
  typedef struct packed {
    logic [3:0]  msg;
    logic        vtx;
    logic        pten;
    logic        tack;
    logic [15:0] lanes;
    logic [3:0]  flags;
  } obs_t;

  typedef struct {
    logic        en;
    logic        v;
    logic [3:0]  msg;
    logic        neg;
    logic        ack;
    logic [15:0] lanes;
    obs_t        exp;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_no  = 0;

  // Reference model: phase 0 idle, 1 await start, 2 point test, 3 await request, 4 finished.
  int   m_phase;
  int   m_buf;
  obs_t m;

  function automatic obs_t dut_obs();
    obs_t o;
    o.msg   = o_sideband_message;
    o.vtx   = o_valid_tx;
    o.pten  = o_point_test_en;
    o.tack  = o_test_ack;
    o.lanes = o_lanes_result;
    o.flags = {o_phy_retrain_req_received, o_speed_degrade_req_received,
               o_repair_req_received, o_error_req_received};
    return o;
  endfunction

  function automatic int flag_idx(input int req);
    case (req)
      3:       return 0;
      5:       return 1;
      7:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m       = '0;
    m_phase = 0;
    m_buf   = -1;
  endtask

  // Each partner request code R is answered with R+1; DONE/exit requests end the test.
  task automatic model_step();
    int src;
    if (i_busy_negedge_detected) m.vtx = 1'b0;
    if (m_phase == 0) begin
      m     = '0;
      m_buf = -1;
      if (i_en) m_phase = 1;
    end else if (!i_en) begin
      m_phase = 0;
    end else begin
      case (m_phase)
        1: if (i_sideband_valid && i_sideband_message == 4'd1) begin
             m.msg = 4'd2; m.vtx = 1'b1; m.pten = 1'b1; m_phase = 2;
           end
        2: begin
             if (i_sideband_valid && i_sideband_message != 4'd1) m_buf = int'(i_sideband_message);
             if (i_point_test_ack) begin
               m.lanes = i_lanes_result; m.pten = 1'b0; m_phase = 3;
             end
           end
        3: begin
             src = -1;
             if (m_buf >= 0) begin
               src   = m_buf;
               m_buf = -1;
             end else if (i_sideband_valid) begin
               src = int'(i_sideband_message);
             end
             if (src inside {3, 5, 7, 9, 11}) begin
               m.msg = 4'(src + 1);
               m.vtx = 1'b1;
               if (src != 9) m.flags[flag_idx(src)] = 1'b1;
               if (src != 3) begin
                 m.tack  = 1'b1;
                 m_phase = 4;
               end
             end
           end
        default: ;
      endcase
    end
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = dut_obs();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got msg=%0d vtx=%b pten=%b tack=%b lanes=%h flags=%b, required msg=%0d vtx=%b pten=%b tack=%b lanes=%h flags=%b",
               name, cyc_no, act.msg, act.vtx, act.pten, act.tack, act.lanes, act.flags,
               exp.msg, exp.vtx, exp.pten, exp.tack, exp.lanes, exp.flags);
    end
  endtask

  task automatic cyc(input logic en, input logic v, input logic [3:0] msg,
                     input logic neg, input logic ack, input logic [15:0] lanes);
    i_en                    = en;
    i_sideband_valid        = v;
    i_sideband_message      = msg;
    i_busy_negedge_detected = neg;
    i_point_test_ack        = ack;
    i_lanes_result          = lanes;
    @(posedge clk);
    cyc_no++;
    model_step();
    #1;
    check("model", m);
  endtask

  function automatic vec_t mk(input logic en, input logic v, input logic [3:0] msg,
                              input logic neg, input logic ack, input logic [15:0] lanes,
                              input logic [3:0] emsg, input logic evtx, input logic epten,
                              input logic etack, input logic [15:0] elanes, input logic [3:0] eflags);
    vec_t t;
    t.en = en; t.v = v; t.msg = msg; t.neg = neg; t.ack = ack; t.lanes = lanes;
    t.exp.msg = emsg; t.exp.vtx = evtx; t.exp.pten = epten; t.exp.tack = etack;
    t.exp.lanes = elanes; t.exp.flags = eflags;
    return t;
  endfunction

  vec_t tbl[33];
  int   reqs[6];

  initial begin
    //            en v msg    neg ack lanes        | msg   vtx pten tack lanes     flags
    tbl[0]  = mk(1, 0, 4'd0,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);
    tbl[1]  = mk(1, 1, 4'd9,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);
    tbl[2]  = mk(1, 0, 4'd1,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);
    tbl[3]  = mk(1, 1, 4'd1,  0, 0, 16'h0000,     4'd2,  1, 1, 0, 16'h0000, 4'b0000);
    tbl[4]  = mk(1, 0, 4'd0,  1, 0, 16'h0000,     4'd2,  0, 1, 0, 16'h0000, 4'b0000);
    tbl[5]  = mk(1, 0, 4'd0,  0, 0, 16'h0000,     4'd2,  0, 1, 0, 16'h0000, 4'b0000);
    tbl[6]  = mk(1, 0, 4'd0,  0, 1, 16'hFFFF,     4'd2,  0, 0, 0, 16'hFFFF, 4'b0000);
    tbl[7]  = mk(1, 1, 4'd9,  0, 0, 16'h0000,     4'd10, 1, 0, 1, 16'hFFFF, 4'b0000);
    tbl[8]  = mk(1, 0, 4'd0,  0, 0, 16'h0000,     4'd10, 1, 0, 1, 16'hFFFF, 4'b0000);
    tbl[9]  = mk(1, 0, 4'd0,  1, 0, 16'h0000,     4'd10, 0, 0, 1, 16'hFFFF, 4'b0000);
    tbl[10] = mk(0, 0, 4'd0,  0, 0, 16'h0000,     4'd10, 0, 0, 1, 16'hFFFF, 4'b0000);
    tbl[11] = mk(0, 0, 4'd0,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);
    // error, then repair, with a valid/negedge collision on the error response
    tbl[12] = mk(1, 0, 4'd0,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);
    tbl[13] = mk(1, 1, 4'd1,  0, 0, 16'h0000,     4'd2,  1, 1, 0, 16'h0000, 4'b0000);
    tbl[14] = mk(1, 0, 4'd0,  0, 1, 16'hA5A5,     4'd2,  1, 0, 0, 16'hA5A5, 4'b0000);
    tbl[15] = mk(1, 1, 4'd3,  1, 0, 16'h0000,     4'd4,  1, 0, 0, 16'hA5A5, 4'b0001);
    tbl[16] = mk(1, 0, 4'd0,  1, 0, 16'h0000,     4'd4,  0, 0, 0, 16'hA5A5, 4'b0001);
    tbl[17] = mk(1, 1, 4'd5,  0, 0, 16'h0000,     4'd6,  1, 0, 1, 16'hA5A5, 4'b0011);
    tbl[18] = mk(0, 0, 4'd0,  0, 0, 16'h0000,     4'd6,  1, 0, 1, 16'hA5A5, 4'b0011);
    tbl[19] = mk(0, 0, 4'd0,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);
    // phy-retrain request parked during the point test
    tbl[20] = mk(1, 0, 4'd0,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);
    tbl[21] = mk(1, 1, 4'd1,  0, 0, 16'h0000,     4'd2,  1, 1, 0, 16'h0000, 4'b0000);
    tbl[22] = mk(1, 1, 4'd11, 0, 0, 16'h0000,     4'd2,  1, 1, 0, 16'h0000, 4'b0000);
    tbl[23] = mk(1, 0, 4'd0,  0, 1, 16'h0F0F,     4'd2,  1, 0, 0, 16'h0F0F, 4'b0000);
    tbl[24] = mk(1, 0, 4'd0,  0, 0, 16'h0000,     4'd12, 1, 0, 1, 16'h0F0F, 4'b1000);
    tbl[25] = mk(0, 0, 4'd0,  0, 0, 16'h0000,     4'd12, 1, 0, 1, 16'h0F0F, 4'b1000);
    tbl[26] = mk(0, 0, 4'd0,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);
    // parked error wins over a live request; then abort from WAIT_REQ
    tbl[27] = mk(1, 0, 4'd0,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);
    tbl[28] = mk(1, 1, 4'd1,  0, 0, 16'h0000,     4'd2,  1, 1, 0, 16'h0000, 4'b0000);
    tbl[29] = mk(1, 1, 4'd3,  0, 1, 16'h1234,     4'd2,  1, 0, 0, 16'h1234, 4'b0000);
    tbl[30] = mk(1, 1, 4'd7,  0, 0, 16'h0000,     4'd4,  1, 0, 0, 16'h1234, 4'b0001);
    tbl[31] = mk(0, 0, 4'd0,  0, 0, 16'h0000,     4'd4,  1, 0, 0, 16'h1234, 4'b0001);
    tbl[32] = mk(0, 0, 4'd0,  0, 0, 16'h0000,     4'd0,  0, 0, 0, 16'h0000, 4'b0000);

    reqs = '{1, 3, 5, 7, 9, 11};

    rst = 1'b1;
    i_en = 1'b0; i_sideband_valid = 1'b0; i_sideband_message = '0;
    i_busy_negedge_detected = 1'b0; i_point_test_ack = 1'b0; i_lanes_result = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset", obs_t'('0));

    for (int i = 0; i < 33; i++) begin
      cyc(tbl[i].en, tbl[i].v, tbl[i].msg, tbl[i].neg, tbl[i].ack, tbl[i].lanes);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // async reset in the middle of the point test
    cyc(1, 0, 4'd0, 0, 0, 16'h0);
    cyc(1, 1, 4'd1, 0, 0, 16'h0);
    cyc(1, 1, 4'd5, 0, 0, 16'h0);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async", obs_t'('0));
    #2;
    rst = 1'b0;
    cyc(1, 0, 4'd0, 0, 1, 16'hBEEF);
    check("post_rst_idle", obs_t'('0));
    cyc(1, 1, 4'd1, 0, 0, 16'h0);
    cyc(1, 0, 4'd0, 0, 1, 16'h8001);
    cyc(1, 0, 4'd0, 0, 0, 16'h0);
    check("post_rst_no_stale_req", m);

    // randomized traffic against the reference model
    for (int k = 0; k < 4000; k++) begin
      logic          r_en, r_v, r_neg, r_ack;
      logic [3:0]    r_msg;
      r_en  = ($urandom_range(0, 99) < 97);
      r_v   = ($urandom_range(0, 99) < 40);
      r_msg = ($urandom_range(0, 1) == 1) ? 4'(reqs[$urandom_range(0, 5)]) : 4'($urandom_range(0, 15));
      r_neg = ($urandom_range(0, 99) < 30);
      r_ack = ($urandom_range(0, 99) < 15);
      cyc(r_en, r_v, r_msg, r_neg, r_ack, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
